// File: rtl/jesd_fifo_pkg.sv
// Shared types and helpers for the JESD207 sample-FIFO controller.
// The state encoding is visible on the STATE port, so the values are fixed.
package jesd_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } fifo_state_e;

  // Number of I/Q pairs held by a RAM with 2^addr_wid entries.
  function automatic int cap_pairs(input int addr_wid);
    return 1 << (addr_wid - 1);
  endfunction

  // A pair occupies two consecutive entries; the wrap bit is dropped.
  function automatic int pair_addr(input int ptr, input int addr_wid);
    return (ptr << 1) & ((1 << addr_wid) - 1);
  endfunction

endpackage

// File: rtl/jesd_fifo_ptr.sv
// Wrap-bit pair pointer with synchronous clear and increment.
// The next value is exported so the parent can register flags from it.
module jesd_fifo_ptr #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr,
  output logic [AW-1:0] ptr_nxt
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr     = ptr_q;
  assign ptr_nxt = ptr_d;

endmodule

// File: rtl/jesd_fifo_ctrl.sv
// Pointer/flag controller for the dual-port sample RAM between the JESD207
// deframer (push side) and the baseband consumer (pop side).
module jesd_fifo_ctrl
  import jesd_fifo_pkg::*;
#(
  parameter int ADDR_WID = 5
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ENABLE,
  input  logic                FLUSH,
  input  logic                PUSH,
  input  logic                POP,
  input  logic [ADDR_WID-1:0] PREFILL,
  input  logic [ADDR_WID-1:0] AF_LVL,
  output logic                RAM_WR_EN,
  output logic [ADDR_WID-1:0] RAM_ADDR_WR,
  output logic                RAM_RD_EN,
  output logic [ADDR_WID-1:0] RAM_ADDR_RD,
  output logic                RD_VALID,
  output logic [ADDR_WID-1:0] LEVEL,
  output logic                FULL,
  output logic                EMPTY,
  output logic                ALMOST_FULL,
  output logic                OVERFLOW,
  output logic                UNDERFLOW,
  output logic [1:0]          STATE
);

  localparam logic [ADDR_WID-1:0] CAP = ADDR_WID'(cap_pairs(ADDR_WID));

  // Handshake: a push is taken when PUSH is high in FILL/RUN and the
  // registered FULL is low; a pop when POP is high in RUN and the registered
  // EMPTY is low. The RAM enable of an accepted transfer is high in that same
  // cycle and the pointer advances on the following edge.

  fifo_state_e         state_q, state_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                af_q, af_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                rd_valid_q, rd_valid_d;

  logic [ADDR_WID-1:0] wptr, wptr_nxt;
  logic [ADDR_WID-1:0] rptr, rptr_nxt;
  logic [ADDR_WID-1:0] level;
  logic [ADDR_WID-1:0] level_d;
  logic [ADDR_WID-1:0] pf_eff;
  logic                wr_state;
  logic                push_ok, push_err;
  logic                pop_ok, pop_err;
  logic                ptr_clr;

  always_comb begin
    wr_state = (state_q == ST_FILL) || (state_q == ST_RUN);
    push_ok  = PUSH & ~full_q & wr_state;
    push_err = PUSH & full_q & wr_state;
    pop_ok   = POP & ~empty_q & (state_q == ST_RUN);
    pop_err  = POP & empty_q & (state_q == ST_RUN);
    ptr_clr  = (state_q == ST_FLUSH);
  end

  jesd_fifo_ptr #(.AW(ADDR_WID)) u_wptr (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (ptr_clr),
    .inc     (push_ok),
    .ptr     (wptr),
    .ptr_nxt (wptr_nxt)
  );

  jesd_fifo_ptr #(.AW(ADDR_WID)) u_rptr (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (ptr_clr),
    .inc     (pop_ok),
    .ptr     (rptr),
    .ptr_nxt (rptr_nxt)
  );

  assign level   = wptr - rptr;
  assign level_d = wptr_nxt - rptr_nxt;

  // A zero prefill would let an empty FIFO enter RUN and underflow at once.
  always_comb begin
    pf_eff = PREFILL;
    if (PREFILL == '0) begin
      pf_eff = ADDR_WID'(1);
    end else if (PREFILL > CAP) begin
      pf_eff = CAP;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_FLUSH) begin
      state_d = ENABLE ? ST_FILL : ST_IDLE;
    end else if (FLUSH) begin
      state_d = ST_FLUSH;
    end else if (!ENABLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: if (level >= pf_eff) state_d = ST_RUN;
        ST_RUN:  if (pop_err) state_d = ST_FILL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    full_d     = (level_d == CAP);
    empty_d    = (level_d == '0);
    af_d       = (level_d >= AF_LVL);
    rd_valid_d = pop_ok;
    ovf_d      = ovf_q | push_err;
    udf_d      = udf_q | pop_err;
    if (state_q == ST_FLUSH) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign RAM_WR_EN   = push_ok;
  assign RAM_RD_EN   = pop_ok;
  assign RAM_ADDR_WR = ADDR_WID'(pair_addr(int'(wptr), ADDR_WID));
  assign RAM_ADDR_RD = ADDR_WID'(pair_addr(int'(rptr), ADDR_WID));
  assign RD_VALID    = rd_valid_q;
  assign LEVEL       = level;
  assign FULL        = full_q;
  assign EMPTY       = empty_q;
  assign ALMOST_FULL = af_q;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = udf_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_jesd_fifo_ctrl.sv
// Bench for jesd_fifo_ctrl: cycle reference model, behavioural RAM and a
// data scoreboard checking FIFO order through the RAM addresses.
module tb_jesd_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [4:0] prefill = 5'd4;
  logic [4:0] af_lvl = 5'd12;
  logic       ram_wr_en, ram_rd_en, rd_valid;
  logic [4:0] ram_addr_wr, ram_addr_rd, level;
  logic       full, empty, almost_full, overflow, underflow;
  logic [1:0] state;

  always #5 clk = ~clk;

  jesd_fifo_ctrl #(.ADDR_WID(5)) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .ENABLE      (enable),
    .FLUSH       (flush),
    .PUSH        (push),
    .POP         (pop),
    .PREFILL     (prefill),
    .AF_LVL      (af_lvl),
    .RAM_WR_EN   (ram_wr_en),
    .RAM_ADDR_WR (ram_addr_wr),
    .RAM_RD_EN   (ram_rd_en),
    .RAM_ADDR_RD (ram_addr_rd),
    .RD_VALID    (rd_valid),
    .LEVEL       (level),
    .FULL        (full),
    .EMPTY       (empty),
    .ALMOST_FULL (almost_full),
    .OVERFLOW    (overflow),
    .UNDERFLOW   (underflow),
    .STATE       (state)
  );

  // Behavioural ramdp: I byte at the even entry, Q byte at the odd entry.
  logic [15:0] wdata = 16'd0;
  logic [7:0]  ram [32];
  logic [15:0] ram_q;
  always @(posedge clk) begin
    if (ram_wr_en) begin
      ram[ram_addr_wr]        <= wdata[15:8];
      ram[ram_addr_wr + 5'd1] <= wdata[7:0];
    end
    if (ram_rd_en) ram_q <= {ram[ram_addr_rd], ram[ram_addr_rd + 5'd1]};
  end

  logic [15:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model (registered view of the controller).
  logic [1:0] m_st;
  logic [4:0] m_wp, m_rp;
  logic       m_full, m_empty, m_af, m_ovf, m_udf, m_rdv;

  task automatic mreset();
    m_st = 2'd0; m_wp = 5'd0; m_rp = 5'd0;
    m_full = 1'b0; m_empty = 1'b1; m_af = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0; m_rdv = 1'b0;
  endtask

  function automatic logic [24:0] dut_vec();
    return {state, level, full, empty, almost_full, overflow, underflow,
            rd_valid, ram_wr_en, ram_rd_en, ram_addr_wr, ram_addr_rd};
  endfunction

  function automatic logic [24:0] model_vec(input logic p, input logic q);
    logic pk, qk;
    logic [4:0] wa, ra;
    pk = p && !m_full && (m_st == 2'd1 || m_st == 2'd2);
    qk = q && !m_empty && (m_st == 2'd2);
    wa = 5'((m_wp % 16) * 2);
    ra = 5'((m_rp % 16) * 2);
    return {m_st, 5'(m_wp - m_rp), m_full, m_empty, m_af, m_ovf, m_udf,
            m_rdv, pk, qk, wa, ra};
  endfunction

  // One clock: drive inputs, check at the falling edge, advance the model.
  task automatic cyc(input logic p, input logic q, input logic f);
    logic       pk, qk, wr_st;
    logic [4:0] lvl, pf, nw, nr, nl;
    logic [1:0] ns;
    logic [15:0] e;
    push = p; pop = q; flush = f;
    wdata = 16'($urandom_range(0, 65535));
    @(negedge clk);
    chk("status", 32'(dut_vec()), 32'(model_vec(p, q)));
    if (m_rdv) begin
      if (exp_q.size() == 0) chk("sb_size", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(ram_q), 32'(e));
      end
    end
    wr_st = (m_st == 2'd1) || (m_st == 2'd2);
    pk  = p && !m_full && wr_st;
    qk  = q && !m_empty && (m_st == 2'd2);
    if (pk) exp_q.push_back(wdata);
    lvl = m_wp - m_rp;
    pf  = (prefill == 5'd0) ? 5'd1 : ((prefill > 5'd16) ? 5'd16 : prefill);
    ns  = m_st;
    if (m_st == 2'd3) begin
      nw = 5'd0; nr = 5'd0; m_ovf = 1'b0; m_udf = 1'b0;
      ns = enable ? 2'd1 : 2'd0;
      exp_q.delete();
    end else begin
      nw = m_wp + {4'd0, pk};
      nr = m_rp + {4'd0, qk};
      if (p && m_full && wr_st) m_ovf = 1'b1;
      if (q && m_empty && m_st == 2'd2) m_udf = 1'b1;
      if (f) ns = 2'd3;
      else if (!enable) ns = 2'd0;
      else if (m_st == 2'd0) ns = 2'd1;
      else if (m_st == 2'd1) ns = (lvl >= pf) ? 2'd2 : 2'd1;
      else if (q && m_empty) ns = 2'd1;
    end
    nl = nw - nr;
    m_full = (nl == 5'd16); m_empty = (nl == 5'd0); m_af = (nl >= af_lvl);
    m_rdv = qk; m_wp = nw; m_rp = nr; m_st = ns;
    @(posedge clk);
    #1;
  endtask

  initial begin
    mreset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_vec", 32'(dut_vec()), 32'(model_vec(1'b0, 1'b0)));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Prime: pops before RUN are ignored, writes land at 0,2,4,6.
    enable = 1'b1;
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_state", 32'(state), 32'd1);
    cyc(0, 0, 0);
    chk("run_entry", 32'(state), 32'd2);
    chk("no_udf_prerun", 32'(underflow), 32'd0);

    // Fill to capacity, then overflow.
    for (int i = 0; i < 12; i++) cyc(1, 0, 0);
    chk("full", 32'(full), 32'd1);
    chk("full_level", 32'(level), 32'd16);
    chk("almost_full", 32'(almost_full), 32'd1);
    cyc(1, 0, 0);
    chk("overflow", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    cyc(1, 1, 0);
    chk("full_pp_level", 32'(level), 32'd15);
    chk("full_pp_rdv", 32'(rd_valid), 32'd1);

    // Steady streaming across the address wrap.
    for (int i = 0; i < 7; i++) cyc(0, 1, 0);
    for (int i = 0; i < 40; i++) cyc(1, 1, 0);
    chk("stream_level", 32'(level), 32'd8);

    // Disable keeps contents; re-enable re-primes from the retained level.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    chk("idle_state", 32'(state), 32'd0);
    enable = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("retain_level", 32'(level), 32'd8);
    chk("retain_run", 32'(state), 32'd2);

    // Drain, underflow, re-prime.
    for (int i = 0; i < 9; i++) cyc(0, 1, 0);
    chk("underflow", 32'(underflow), 32'd1);
    chk("udf_state", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("reprime_run", 32'(state), 32'd2);

    // Flush mid-stream clears contents and sticky flags.
    for (int i = 0; i < 5; i++) cyc(1, 1, 0);
    cyc(0, 0, 1);
    chk("flush_state", 32'(state), 32'd3);
    cyc(0, 0, 0);
    chk("post_flush_state", 32'(state), 32'd1);
    chk("post_flush_level", 32'(level), 32'd0);
    chk("post_flush_empty", 32'(empty), 32'd1);
    chk("post_flush_ovf", 32'(overflow), 32'd0);
    chk("post_flush_udf", 32'(underflow), 32'd0);

    // Prefill clamp: 0 behaves as 1, 31 behaves as 16.
    enable = 1'b0;
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    prefill = 5'd0;
    enable = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("pf0_run", 32'(state), 32'd2);
    enable = 1'b0;
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    prefill = 5'd31;
    enable = 1'b1;
    cyc(0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("pf31_hold", 32'(state), 32'd1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("pf31_run", 32'(state), 32'd2);
    enable = 1'b0;
    cyc(0, 0, 0);
    prefill = 5'd4;
    enable = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    cyc(1, 1, 0);

    // Asynchronous reset between edges while a push is being accepted.
    push = 1'b1; pop = 1'b1;
    @(posedge clk); #3;
    chk("pre_rst_wren", 32'(ram_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    mreset();
    exp_q.delete();
    chk("async_rst", 32'(dut_vec()), 32'(model_vec(push, pop)));
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cyc(logic'($urandom_range(0, 99) < 55), logic'($urandom_range(0, 99) < 50), 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
